prbs_randomizer_par: RTL
========================

PRBS_RANDOMIZER_PAR -- requirements
Module: prbs_randomizer_par

Interface
REQ-001 Parameter DATA_W, default 8, bits processed per transfer; legal range 1..16.
REQ-002 Parameter BLOCK_BITS, default 96, bits per randomization block; SHALL be a multiple of DATA_W; elaboration error otherwise.
REQ-003 Parameter SEED_RST, default 15'h3715, seed register value after reset.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  1 = randomize; 0 = bypass, data passes unmodified and the LFSR does not advance.
REQ-007 len  input  1  seed write strobe, one-cycle pulse.
REQ-008 load  input  15  seed value, captured when len=1.
REQ-009 in_valid / in_ready  input / output  1 / 1  input word handshake.
REQ-010 input_data  input  DATA_W  input word; MSB is the first bit in time.
REQ-011 in_sop  input  1  marks the first word of a block; qualified by in_valid.
REQ-012 out_valid / out_ready  output / input  1 / 1  output word handshake.
REQ-013 output_data  output  DATA_W  randomized word.
REQ-014 out_eob  output  1  marks the last word of a block; qualified by out_valid.
REQ-015 blk_err  output  1  sticky flag: in_sop arrived mid-block; cleared only by reset.

Function
REQ-016 LFSR polynomial 1+x^14+x^15; state s[14:0], s[14] = stage 1, s[0] = stage 15.
REQ-017 Per bit: fb = s[1]^s[0]; out_bit = in_bit^fb; s_next = {fb, s[14:1]}.
REQ-018 Per accepted word: DATA_W bit steps in one cycle, MSB first; output bit k uses the state after DATA_W-1-k prior steps within the word.
REQ-019 Transfer occurs when in_valid && in_ready.
REQ-020 in_ready = !out_valid || out_ready, combinational; no other dependency.
REQ-021 Output register: one stage; latency exactly 1 cycle from input transfer to out_valid.
REQ-022 Output data stability: output_data, out_eob and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Block state machine: IDLE and RUN.
REQ-024 IDLE to RUN: transfer with in_sop=1; the LFSR is loaded from the seed register before that word is processed; the word counter is set to 1.
REQ-025 Transfer in IDLE with in_sop=0: word passes through unrandomized; state stays IDLE; out_eob=0.
REQ-026 RUN: each transfer increments the word counter.
REQ-027 RUN end of block: on the word where counter reaches BLOCK_BITS/DATA_W, out_eob=1 on that output word and the FSM returns to IDLE.
REQ-028 RUN, in_sop=1 with counter < BLOCK_BITS/DATA_W: set blk_err; restart the block per REQ-024, with the LFSR reseeded before that word.
REQ-029 BLOCK_BITS == DATA_W: every word with in_sop=1 is a full block; out_eob=1 on every such output word.
REQ-030 Seed write, len=1: the seed register updates next edge and affects only subsequent block starts.
REQ-031 Seed write, len=1 in the same cycle as an in_sop transfer: the block uses the new load value.
REQ-032 en=0 during RUN: data bypassed; LFSR frozen; the counter still advances.
REQ-033 The LFSR never enters the all-zero state unless the seed is 0; seed 0 is legal and yields pass-through.

Reset
REQ-034 Reset asserted (reset=0), asynchronously: FSM=IDLE; counter=0; s=SEED_RST; seed register=SEED_RST; out_valid=0; output_data=0; out_eob=0; blk_err=0.
REQ-035 Reset release: in_ready=1 on the first cycle after release.
REQ-036 Reset mid-block: the partial block is discarded; no out_eob is emitted for it.

Verification
REQ-037 DATA_W=8, BLOCK_BITS=96, default seed, input ACBCD2114DAE1577C6DBF4C9 (in_sop on the first byte) -> output 558AC4A53A1724E163AC2BF9; out_eob on the 12th byte only.
REQ-038 DATA_W=1, same vector, 96 transfers -> same 96-bit output stream; latency 1 cycle per bit.
REQ-039 Random out_ready backpressure on the REQ-037 stream -> identical output; no word lost or duplicated; output held stable while stalled.
REQ-040 len with load=15'h7FFF mid-block -> current block unchanged; the next block is randomized with seed 7FFF (compare against model).
REQ-041 in_sop on the 5th word of a block -> blk_err=1; output restarts from the seed sequence at that word.
REQ-042 Reset pulse on the 6th word, then the REQ-037 stream -> output identical to REQ-037.

Source files
------------

// File: rtl/prbs_randomizer_par.sv
// Parallel PRBS randomizer (1 + x^14 + x^15) that processes DATA_W bits per transfer.
// Blocks start on in_sop and span BLOCK_BITS bits. A single output register stage follows.
module prbs_randomizer_par #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BLOCK_BITS = 96,
    parameter logic [14:0] SEED_RST   = 15'h3715
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              len,
    input  logic [14:0]       load,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] input_data,
    input  logic              in_sop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] output_data,
    output logic              out_eob,
    output logic              blk_err
);

    if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
        $error("DATA_W must be in 1..16");
    end
    if (BLOCK_BITS == 0 || (BLOCK_BITS % DATA_W) != 0) begin : g_bad_block_bits
        $error("BLOCK_BITS must be a non-zero multiple of DATA_W");
    end

    localparam int unsigned WordsPerBlk = BLOCK_BITS / DATA_W;
    localparam int unsigned CntW        = (WordsPerBlk < 2) ? 1 : $clog2(WordsPerBlk + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WordsPerBlk);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [14:0]       lfsr_q, lfsr_d;
    logic [14:0]       seed_q, seed_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_eob_q, out_eob_d;
    logic              blk_err_q, blk_err_d;

    logic              fire;
    logic              run_word;
    logic [14:0]       lfsr_base;
    logic [CntW-1:0]   cnt_base;
    logic [CntW-1:0]   cnt_inc;
    logic [DATA_W-1:0] scr_data;
    logic [14:0]       scr_lfsr;

    assign in_ready    = !out_valid_q || out_ready;
    assign fire        = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign output_data = out_data_q;
    assign out_eob     = out_eob_q;
    assign blk_err     = blk_err_q;

    // Starting point for the current word: a block start reseeds from the seed being
    // written this cycle if there is one, so a same-cycle seed write takes effect.
    always_comb begin
        lfsr_base = lfsr_q;
        cnt_base  = cnt_q;
        run_word  = (state_q == StRun);
        if (in_sop) begin
            lfsr_base = len ? load : seed_q;
            cnt_base  = '0;
            run_word  = 1'b1;
        end
        cnt_inc = cnt_base + CntW'(1);
    end

    // DATA_W serial LFSR steps unrolled, MSB first in time.
    always_comb begin
        logic [14:0] st;
        logic        fb;
        st       = lfsr_base;
        fb       = 1'b0;
        scr_data = '0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb          = st[1] ^ st[0];
            scr_data[i] = input_data[i] ^ fb;
            st          = {fb, st[14:1]};
        end
        scr_lfsr = st;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        seed_d      = len ? load : seed_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eob_d   = out_eob_q;
        blk_err_d   = blk_err_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (fire) begin
            out_valid_d = 1'b1;
            out_eob_d   = 1'b0;
            out_data_d  = input_data;
            if (run_word) begin
                if (in_sop && state_q == StRun) begin
                    blk_err_d = 1'b1;
                end
                // Bypass freezes the LFSR, but a block start still reseeds it.
                if (en) begin
                    out_data_d = scr_data;
                    lfsr_d     = scr_lfsr;
                end else begin
                    lfsr_d     = lfsr_base;
                end
                if (cnt_inc == LastCnt) begin
                    out_eob_d = 1'b1;
                    state_d   = StIdle;
                    cnt_d     = '0;
                end else begin
                    state_d   = StRun;
                    cnt_d     = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            lfsr_q      <= SEED_RST;
            seed_q      <= SEED_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eob_q   <= 1'b0;
            blk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eob_q   <= out_eob_d;
            blk_err_q   <= blk_err_d;
        end
    end

endmodule
